seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Parametrised, time-multiplexed seven-segment scan controller; next generation of the six-digit display driver. Adds:
- configurable digit count and scan rate
- double-buffered, tear-free data loading
- per-digit decimal points and leading-zero blanking
- PWM brightness and an anti-ghosting guard interval

Sits between the vending datapath (price/credit/change digits) and the board's digit-select and segment pins.

Parameters:
NUM_DIGITS, 6, number of multiplexed digits (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at start of each slot with all digits disabled (>= 0, < SCAN_DIV)
BRIGHT_W, 4, brightness control width
ACTIVE_LOW, 1, 1 = addr and out asserted low (common anode); 0 = asserted high

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
data_in  in  4*NUM_DIGITS  packed hex digits; digit k = data_in[4k+3:4k]; digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
load  in  1  one-cycle strobe; captures data_in/dp_in into shadow
blank_lz  in  1  1 = suppress leading zeros
brightness  in  BRIGHT_W  duty control; 0 = dark, all-ones = full on
addr  out  NUM_DIGITS  one-hot digit select (polarity per ACTIVE_LOW)
out  out  8  segments: out[7] = dp, out[6:0] = g,f,e,d,c,b,a (polarity per ACTIVE_LOW)
frame_done  out  1  one-cycle pulse at end of the last digit slot

Behaviour:
- Reset (asynchronous, reset == 0):
  - slot counter, digit index, PWM counter = 0
  - shadow and display buffers = 0; pending = 0
  - addr all inactive, out all segments off, frame_done = 0
  - Takes effect immediately mid-frame; scanning resumes from digit 0 slot start on the first clk after release.
- Slot counter: counts 0..SCAN_DIV-1, then wraps.
  - At terminal count, digit index increments.
  - Index wraps NUM_DIGITS-1 -> 0; frame_done = 1 for that single cycle.
- Frame boundary = cycle where frame_done is asserted.
- Loading:
  - load = 1 -> shadow <= {dp_in, data_in}, pending <= 1.
  - At frame boundary with pending = 1: display <= shadow, pending <= 0.
  - load coinciding with frame boundary: data_in/dp_in go directly to display; pending stays 0.
  - Repeated loads in one frame: last one wins.
  - Display never changes mid-frame.
- Digit enable: enable = (slot_cnt >= GUARD) AND pwm_on.
  - PWM counter: free-running BRIGHT_W-bit counter, increments every clk, wraps naturally.
  - pwm_on = (pwm_cnt < brightness), or 1 when brightness is all-ones.
- Decode, on display buffer digit [index]:
  - 0-9 and A-F use standard hex glyphs (0 = a-f lit; 1 = b,c; 8 = all; A = a,b,c,e,f,g; b = c,d,e,f,g; C = a,d,e,f; d = b,c,d,e,g; E = a,d,e,f,g; F = a,e,f,g).
  - dp from display dp bit.
- Leading-zero blanking (blank_lz = 1):
  - Digit k (k >= 1) is blanked (segments a-g off) when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - dp is still shown on a blanked digit.
  - Evaluated on the display buffer.
- Output timing:
  - addr and out are registered, with 1 cycle latency from counter/index state.
  - When enable = 0: addr all inactive; out holds the current glyph.
  - When enable = 1: addr[index] active, others inactive.
- Polarity: ACTIVE_LOW inverts addr and out only; internal logic is active-high.
- Widths:
  - Slot counter width = clog2(SCAN_DIV).
  - Index width = clog2(NUM_DIGITS), minimum 1.
  - Only values 0..NUM_DIGITS-1 are reachable.

Test Plan:
All scenarios use NUM_DIGITS = 6, SCAN_DIV = 8, GUARD = 1, BRIGHT_W = 2, ACTIVE_LOW = 0.
1. Reset/scan: reset = 0 for 2 cycles, then release with brightness = 3 -> addr = 0 and out = 0 during reset. Then addr visits 000001..100000, each slot active for 7 of 8 cycles. frame_done pulses every 48 cycles.
2. Decode: load data_in = 0x123456, dp_in = 6'b000100, frame boundary passes -> slot 0 out = 0x7D ("6"); slot 2 out = 0xE6 ("4" + dp); slot 5 out = 0x06 ("1").
3. Tear-free load: mid-frame load of 0x999999 -> remaining slots of the current frame still show the old digits; new value appears from digit 0 of the next frame. Load on the frame_done cycle -> new value shows immediately in the next frame.
4. Leading zeros: data 0x000070, blank_lz = 1 -> digits 5..2 show out[6:0] = 0; digit 1 = 0x07; digit 0 = 0x3F. Same data with 0x000000 -> only digit 0 is lit, out = 0x3F.
5. Brightness: brightness = 0 -> addr always 0. brightness = 1 -> within the enabled part of each slot, addr is active 1 of every 4 cycles.
6. Mid-frame reset: assert reset during slot 3 -> addr and out go to 0 without waiting for a clock edge, display buffer is cleared, scanning restarts at digit 0 after release.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Time-multiplexed seven-segment scanner: double-buffered digit data, leading-zero
// blanking, PWM dimming and a per-slot guard window to suppress ghosting.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16,
    parameter int BRIGHT_W   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   addr,
    output logic [7:0]              out,
    output logic                    frame_done
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 5 * NUM_DIGITS;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [SW-1:0] GUARD_CNT = SW'(GUARD);

    logic [SW-1:0]         slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    // Buffers hold {dp[NUM_DIGITS-1:0], hex digits} so one capture moves both.
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] addr_q, addr_d;
    logic [7:0]            seg_q, seg_d;

    logic                  slot_tc;
    logic                  frame_end;
    logic                  pwm_on;
    logic                  enable;
    logic [3:0]            cur_dig;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        slot_tc    = (slot_cnt_q == SLOT_LAST);
        frame_end  = slot_tc && (idx_q == IDX_LAST);
        slot_cnt_d = slot_tc ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (slot_tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;
    end

    // The display buffer only ever changes on the frame boundary.
    always_comb begin
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (frame_end) begin
            if (load) begin
                disp_d = {dp_in, data_in};
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = shadow_q;
                pend_d = 1'b0;
            end
        end else if (load) begin
            shadow_d = {dp_in, data_in};
            pend_d   = 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero while
    // every digit from the top down to it reads zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run && (k != 0);
        end
    end

    always_comb begin
        cur_dig   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_dig   = disp_q[4*k +: 4];
                cur_dp    = disp_q[4*NUM_DIGITS + k];
                cur_blank = blank_lz && lz_mask[k];
            end
        end
    end

    always_comb begin
        pwm_on = (brightness == '1) || (pwm_q < brightness);
        enable = (slot_cnt_q >= GUARD_CNT) && pwm_on;
        addr_d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            addr_d[k] = enable && (idx_q == IW'(k));
        end
        seg_d = {cur_dp, (cur_blank ? 7'h00 : hex_glyph(cur_dig))};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            pwm_q      <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            pend_q     <= 1'b0;
            addr_q     <= '0;
            seg_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            pwm_q      <= pwm_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            seg_q      <= seg_d;
        end
    end

    assign addr       = ACTIVE_LOW ? ~addr_q : addr_q;
    assign out        = ACTIVE_LOW ? ~seg_q  : seg_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for seven_seg_scan_ctrl (6 digits, 8-cycle slots, 1-cycle guard, 2-bit PWM)
// against a reference model driven by elapsed-cycle arithmetic.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 6;
    localparam int SD    = 8;
    localparam int GD    = 1;
    localparam int FRAME = ND * SD;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [23:0] data_in    = '0;
    logic [5:0]  dp_in      = '0;
    logic        load       = 1'b0;
    logic        blank_lz   = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [5:0]  addr;
    logic [7:0]  out;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .GUARD     (GD),
        .BRIGHT_W  (2),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .brightness(brightness),
        .addr      (addr),
        .out       (out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: m_n = clock edges since reset release.
    int          m_n    = 0;
    logic [23:0] m_dd   = '0;
    logic [5:0]  m_dp   = '0;
    logic [23:0] m_sd   = '0;
    logic [5:0]  m_sp   = '0;
    logic        m_pend = 1'b0;
    logic [5:0]  e_addr = '0;
    logic [7:0]  e_out  = '0;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h3F;   1: return 7'h06;   2: return 7'h5B;   3: return 7'h4F;
            4: return 7'h66;   5: return 7'h6D;   6: return 7'h7D;   7: return 7'h07;
            8: return 7'h7F;   9: return 7'h6F;  10: return 7'h77;  11: return 7'h7C;
           12: return 7'h39;  13: return 7'h5E;  14: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input logic [23:0] d, input logic [5:0] dp,
                                             input int k, input logic lz);
        logic [23:0] upper;
        logic        blank;
        upper = d >> (4 * k);
        blank = lz && (k > 0) && (upper == 24'h0);
        return {dp[k], (blank ? 7'h00 : glyph(int'(upper[3:0])))};
    endfunction

    function automatic logic [5:0] model_addr(input int n, input logic [1:0] br);
        int  slot;
        int  idx;
        logic on;
        slot = n % SD;
        idx  = (n / SD) % ND;
        on   = (slot >= GD) && ((br == 2'd3) || ((n % 4) < int'(br)));
        return on ? 6'(1 << idx) : 6'h00;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n    <= 0;
            m_dd   <= '0;
            m_dp   <= '0;
            m_sd   <= '0;
            m_sp   <= '0;
            m_pend <= 1'b0;
            e_addr <= '0;
            e_out  <= '0;
        end else begin
            e_addr <= model_addr(m_n, brightness);
            e_out  <= model_seg(m_dd, m_dp, (m_n / SD) % ND, blank_lz);
            if ((m_n % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_dd   <= data_in;
                    m_dp   <= dp_in;
                    m_pend <= 1'b0;
                end else if (m_pend) begin
                    m_dd   <= m_sd;
                    m_dp   <= m_sp;
                    m_pend <= 1'b0;
                end
            end else if (load) begin
                m_sd   <= data_in;
                m_sp   <= dp_in;
                m_pend <= 1'b1;
            end
            m_n <= m_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("addr", 32'(addr), 32'(e_addr));
        check("out", 32'(out), 32'(e_out));
        check("frame_done", 32'(frame_done), 32'((m_n % FRAME) == FRAME - 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] p);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic wait_digit(input int k, output int waited);
        logic found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 200) begin
            tick();
            waited++;
            if (addr == 6'(1 << k)) found = 1'b1;
        end
        check($sformatf("wait_digit%0d", k), 32'(found), 32'd1);
    endtask

    task automatic wait_fd();
        logic found;
        int   n;
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            tick();
            n++;
            if (frame_done) found = 1'b1;
        end
        check("wait_frame_done", 32'(found), 32'd1);
    endtask

    task automatic digit_is(input int k, input logic [7:0] v, input string tag);
        int w;
        wait_digit(k, w);
        check(tag, 32'(out), 32'(v));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w;
        int          t0;
        int          cnt;
        logic [23:0] rd;

        // Reset and basic scan timing
        #1 reset = 1'b0;
        #2;
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        tick();
        tick();
        reset = 1'b1;
        wait_digit(0, w);
        check("first_active_latency", 32'(w), 32'd2);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (addr == 6'b000001) cnt++;
            else break;
        end
        check("slot_active_cycles", 32'(cnt), 32'd7);
        wait_fd();
        t0 = cyc;
        wait_fd();
        check("frame_period", 32'(cyc - t0), 32'(FRAME));

        // Decode
        repeat (5) tick();
        do_load(24'h123456, 6'b000100);
        wait_fd();
        digit_is(0, 8'h7D, "dec_d0_6");
        digit_is(2, 8'hE6, "dec_d2_4dp");
        digit_is(5, 8'h06, "dec_d5_1");

        // Tear-free loading
        digit_is(2, 8'hE6, "pre_load_d2");
        do_load(24'h999999, 6'b000000);
        digit_is(3, 8'h4F, "old_frame_d3");
        digit_is(5, 8'h06, "old_frame_d5");
        digit_is(0, 8'h6F, "new_frame_d0");
        wait_fd();
        do_load(24'hABCDEF, 6'b000001);
        digit_is(0, 8'hF1, "boundary_load_d0");
        digit_is(5, 8'h77, "boundary_load_d5");

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(24'h000070, 6'b000000);
        wait_fd();
        digit_is(0, 8'h3F, "lz_d0");
        digit_is(1, 8'h07, "lz_d1");
        digit_is(2, 8'h00, "lz_d2");
        digit_is(5, 8'h00, "lz_d5");
        do_load(24'h000000, 6'b010000);
        wait_fd();
        digit_is(0, 8'h3F, "lz_all0_d0");
        digit_is(1, 8'h00, "lz_all0_d1");
        digit_is(4, 8'h80, "lz_dp_on_blank");

        // Brightness
        brightness = 2'd0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("dark_addr", 32'(addr), 32'h0);
        end
        brightness = 2'd1;
        cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (addr != 6'h00) cnt++;
        end
        check("pwm1_active_per_frame", 32'(cnt), 32'd6);

        // Randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            if (i % 60 == 0) brightness = 2'($urandom_range(0, 3));
            if (i % 150 == 0) blank_lz = 1'($urandom_range(0, 1));
            if ((((m_n % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1)) ||
                ($urandom_range(0, 19) == 0)) begin
                rd = 24'($urandom);
                rd = rd >> (4 * $urandom_range(0, 6));
                do_load(rd, 6'($urandom));
            end else begin
                tick();
            end
        end

        // Mid-frame asynchronous reset
        brightness = 2'd3;
        blank_lz   = 1'b0;
        do_load(24'h654321, 6'b000000);
        wait_fd();
        digit_is(3, 8'h66, "pre_reset_d3");
        reset = 1'b0;
        #2;
        check("midrst_addr", 32'(addr), 32'h0);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_fd", 32'(frame_done), 32'h0);
        check_model();
        tick();
        tick();
        reset = 1'b1;
        wait_digit(0, w);
        check("restart_latency", 32'(w), 32'd2);
        check("restart_d0_cleared", 32'(out), 32'h3F);
        digit_is(1, 8'h3F, "restart_d1_cleared");
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
